// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between the integer issue port (0)
// and the branch/address port (1). Round-robin grant, valid/ready on both request
// ports, and one registered result stage (depth one, no internal queue).
module alu_share_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             req0_valid_in,
  output logic             req0_ready_out,
  input  logic [XLEN-1:0]  req0_a_in,
  input  logic [XLEN-1:0]  req0_b_in,
  input  logic [3:0]       req0_uop_in,
  input  logic [TAG_W-1:0] req0_tag_in,
  input  logic             req1_valid_in,
  output logic             req1_ready_out,
  input  logic [XLEN-1:0]  req1_a_in,
  input  logic [XLEN-1:0]  req1_b_in,
  input  logic [3:0]       req1_uop_in,
  input  logic [TAG_W-1:0] req1_tag_in,
  output logic [XLEN-1:0]  alu_a_out,
  output logic [XLEN-1:0]  alu_b_out,
  output logic [3:0]       alu_uop_out,
  input  logic [XLEN-1:0]  alu_result_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [XLEN-1:0]  res_data_out,
  output logic             res_src_out,
  output logic [TAG_W-1:0] res_tag_out
);

  logic             r_last_grant;
  logic             r_res_valid;
  logic [XLEN-1:0]  r_res_data;
  logic             r_res_src;
  logic [TAG_W-1:0] r_res_tag;

  logic             w_grant_valid;
  logic             w_grant_sel;
  logic             w_accept;
  logic [TAG_W-1:0] w_grant_tag;

  // Round-robin grant: a lone requester always wins; on contention the port that
  // did not win the last accepted op goes first.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_sel   = 1'b0;
    case ({req1_valid_in, req0_valid_in})
      2'b01: begin
        w_grant_valid = 1'b1;
        w_grant_sel   = 1'b0;
      end
      2'b10: begin
        w_grant_valid = 1'b1;
        w_grant_sel   = 1'b1;
      end
      2'b11: begin
        w_grant_valid = 1'b1;
        w_grant_sel   = ~r_last_grant;
      end
      default: begin
        w_grant_valid = 1'b0;
        w_grant_sel   = 1'b0;
      end
    endcase
  end

  // Accept only when the output stage is empty or being drained this cycle;
  // reset suppresses every handshake.
  assign w_accept = w_grant_valid && (!r_res_valid || res_ready_in) && !reset_in;

  assign req0_ready_out = w_accept && (w_grant_sel == 1'b0);
  assign req1_ready_out = w_accept && (w_grant_sel == 1'b1);

  // Operand mux to the ALU; with no grant port 0 is driven so the ALU inputs stay deterministic.
  always_comb begin
    alu_a_out   = req0_a_in;
    alu_b_out   = req0_b_in;
    alu_uop_out = req0_uop_in;
    w_grant_tag = req0_tag_in;
    if (w_grant_valid && w_grant_sel) begin
      alu_a_out   = req1_a_in;
      alu_b_out   = req1_b_in;
      alu_uop_out = req1_uop_in;
      w_grant_tag = req1_tag_in;
    end else begin
      alu_a_out   = req0_a_in;
      alu_b_out   = req0_b_in;
      alu_uop_out = req0_uop_in;
      w_grant_tag = req0_tag_in;
    end
  end

  // Output stage and priority pointer: load on accept, clear valid on a pure drain,
  // hold everything (including priority) under backpressure or idle.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_last_grant <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_data   <= {XLEN{1'b0}};
      r_res_src    <= 1'b0;
      r_res_tag    <= {TAG_W{1'b0}};
    end else if (w_accept) begin
      r_last_grant <= w_grant_sel;
      r_res_valid  <= 1'b1;
      r_res_data   <= alu_result_in;
      r_res_src    <= w_grant_sel;
      r_res_tag    <= w_grant_tag;
    end else if (r_res_valid && res_ready_in) begin
      r_res_valid  <= 1'b0;
    end
  end

  assign res_valid_out = r_res_valid;
  assign res_data_out  = r_res_data;
  assign res_src_out   = r_res_src;
  assign res_tag_out   = r_res_tag;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small ALU stand-in
// (uop 0 = add, uop 1 = sub, others = xor). Expected values are hand-computed.
module tb_alu_share_arbiter;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clock_in;
  logic             reset_in;
  logic             req0_valid_in, req0_ready_out;
  logic [XLEN-1:0]  req0_a_in, req0_b_in;
  logic [3:0]       req0_uop_in;
  logic [TAG_W-1:0] req0_tag_in;
  logic             req1_valid_in, req1_ready_out;
  logic [XLEN-1:0]  req1_a_in, req1_b_in;
  logic [3:0]       req1_uop_in;
  logic [TAG_W-1:0] req1_tag_in;
  logic [XLEN-1:0]  alu_a_out, alu_b_out, alu_result_in;
  logic [3:0]       alu_uop_out;
  logic             res_valid_out, res_ready_in, res_src_out;
  logic [XLEN-1:0]  res_data_out;
  logic [TAG_W-1:0] res_tag_out;

  int n_checks = 0;
  int n_errors = 0;

  alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock_in(clock_in), .reset_in(reset_in),
    .req0_valid_in(req0_valid_in), .req0_ready_out(req0_ready_out),
    .req0_a_in(req0_a_in), .req0_b_in(req0_b_in), .req0_uop_in(req0_uop_in), .req0_tag_in(req0_tag_in),
    .req1_valid_in(req1_valid_in), .req1_ready_out(req1_ready_out),
    .req1_a_in(req1_a_in), .req1_b_in(req1_b_in), .req1_uop_in(req1_uop_in), .req1_tag_in(req1_tag_in),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_uop_out(alu_uop_out),
    .alu_result_in(alu_result_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_data_out(res_data_out), .res_src_out(res_src_out), .res_tag_out(res_tag_out)
  );

  // ALU stand-in
  always_comb begin
    case (alu_uop_out)
      4'h0:    alu_result_in = alu_a_out + alu_b_out;
      4'h1:    alu_result_in = alu_a_out - alu_b_out;
      default: alu_result_in = alu_a_out ^ alu_b_out;
    endcase
  end

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic set0(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [3:0] u, input logic [TAG_W-1:0] t);
    req0_valid_in = v; req0_a_in = a; req0_b_in = b; req0_uop_in = u; req0_tag_in = t;
  endtask

  task automatic set1(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [3:0] u, input logic [TAG_W-1:0] t);
    req1_valid_in = v; req1_a_in = a; req1_b_in = b; req1_uop_in = u; req1_tag_in = t;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [XLEN-1:0] d,
                         input logic s, input logic [TAG_W-1:0] t);
    chk({tag, ".valid"}, 64'(res_valid_out), 64'(v));
    chk({tag, ".data"},  64'(res_data_out),  64'(d));
    chk({tag, ".src"},   64'(res_src_out),   64'(s));
    chk({tag, ".tag"},   64'(res_tag_out),   64'(t));
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".rdy0"}, 64'(req0_ready_out), 64'(r0));
    chk({tag, ".rdy1"}, 64'(req1_ready_out), 64'(r1));
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    tick();
    tick();
    reset_in = 1'b0;
  endtask

  initial begin
    reset_in = 1'b1;
    res_ready_in = 1'b1;
    set0(1'b0, 32'd0, 32'd0, 4'h0, 5'd0);
    set1(1'b0, 32'd0, 32'd0, 4'h0, 5'd0);
    #1;
    do_reset();
    chk_res("reset", 1'b0, 32'd0, 1'b0, 5'd0);

    // 1: single op on port 0, one-cycle latency
    set0(1'b1, 32'd5, 32'd7, 4'h0, 5'd3);
    #1;
    chk_rdy("t1", 1'b1, 1'b0);
    chk("t1.alu_a", 64'(alu_a_out), 64'd5);
    tick();
    set0(1'b0, 32'd5, 32'd7, 4'h0, 5'd3);
    chk_res("t1.res", 1'b1, 32'd12, 1'b0, 5'd3);
    tick();
    chk_res("t1.drain", 1'b0, 32'd12, 1'b0, 5'd3);

    // 2: contention alternates 0,1,0,1,0 from reset, no bubbles
    do_reset();
    set0(1'b1, 32'd10, 32'd1, 4'h0, 5'd1);
    set1(1'b1, 32'd20, 32'd5, 4'h1, 5'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_rdy("t2", (i % 2) == 0, (i % 2) == 1);
      tick();
      if ((i % 2) == 0) chk_res("t2.res0", 1'b1, 32'd11, 1'b0, 5'd1);
      else              chk_res("t2.res1", 1'b1, 32'd15, 1'b1, 5'd2);
    end

    // 3: backpressure for 4 cycles; pending loser (port 1) goes first on release
    res_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_rdy("t3.stall", 1'b0, 1'b0);
      tick();
      chk_res("t3.hold", 1'b1, 32'd11, 1'b0, 5'd1);
    end
    res_ready_in = 1'b1;
    #1;
    chk_rdy("t3.release", 1'b0, 1'b1);
    tick();
    chk_res("t3.res", 1'b1, 32'd15, 1'b1, 5'd2);

    // 4/5: only port 1 valid with last_grant=1, back-to-back; drain+accept reloads
    set0(1'b0, 32'd0, 32'd0, 4'h0, 5'd0);
    set1(1'b1, 32'd30, 32'd3, 4'h1, 5'd4);
    #1;
    chk_rdy("t4.op0", 1'b0, 1'b1);
    tick();
    chk_res("t4.r0", 1'b1, 32'd27, 1'b1, 5'd4);
    set1(1'b1, 32'd7, 32'd2, 4'h2, 5'd5);
    #1;
    chk_rdy("t4.op1", 1'b0, 1'b1);
    tick();
    chk_res("t4.r1", 1'b1, 32'd5, 1'b1, 5'd5);
    set1(1'b1, 32'd1, 32'd1, 4'h0, 5'd6);
    #1;
    chk_rdy("t4.op2", 1'b0, 1'b1);
    tick();
    chk_res("t5.reload", 1'b1, 32'd2, 1'b1, 5'd6);
    set0(1'b1, 32'd10, 32'd1, 4'h0, 5'd1);
    set1(1'b1, 32'd20, 32'd5, 4'h1, 5'd2);
    #1;
    chk_rdy("t4.contend", 1'b1, 1'b0);
    tick();
    chk_res("t4.p0win", 1'b1, 32'd11, 1'b0, 5'd1);

    // 6: reset with a result held and both requesters valid
    reset_in = 1'b1;
    #1;
    chk_rdy("t6.inreset", 1'b0, 1'b0);
    tick();
    reset_in = 1'b0;
    chk_res("t6.cleared", 1'b0, 32'd0, 1'b0, 5'd0);
    #1;
    chk_rdy("t6.first", 1'b1, 1'b0);
    tick();
    chk_res("t6.res", 1'b1, 32'd11, 1'b0, 5'd1);

    // idle cycle must not rotate priority: port 1 still next
    set0(1'b0, 32'd10, 32'd1, 4'h0, 5'd1);
    set1(1'b0, 32'd20, 32'd5, 4'h1, 5'd2);
    tick();
    chk_res("idle.drain", 1'b0, 32'd11, 1'b0, 5'd1);
    set0(1'b1, 32'd10, 32'd1, 4'h0, 5'd1);
    set1(1'b1, 32'd20, 32'd5, 4'h1, 5'd2);
    #1;
    chk_rdy("idle.next", 1'b0, 1'b1);
    tick();
    chk_res("idle.res", 1'b1, 32'd15, 1'b1, 5'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
